ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch initiator that drives the synchronous-read instruction memory. The memory has 1-cycle read latency, takes a word-aligned pc and a kill input, and returns an all-zero word when killed.
The block generates sequential PCs, tracks the in-flight read and buffers returned words in a small fetch queue. It presents {pc, inst} to decode with a valid/ready handshake and handles control-flow redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FQ_DEPTH, 4, fetch-queue entries (power of two, >= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_pc  out  32  fetch address to instruction memory (sampled every clk edge)
imem_kill  out  1  to memory is_jump; squashes the read presented this cycle
imem_inst  in  32  memory read data, valid 1 cycle after address presented
redirect_valid  in  1  control-flow change, single-cycle pulse
redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head
out_pc  out  32  pc of head instruction
out_inst  out  32  head instruction word

Behaviour:
- Reset (async assert, sync deassert by user): pc_q=RESET_PC, inflight_q=0, queue empty.
- Output values under reset: imem_pc=RESET_PC, imem_kill=0, out_valid=0, out_pc=0, out_inst=0.
- out_pc and out_inst are driven 0 whenever the queue is empty.
- imem_pc = pc_q, except in a redirect cycle, where imem_pc = redirect_pc.
- Issue condition: issue = !redirect_valid && (count + inflight_q - pop) < FQ_DEPTH, where pop = out_valid && out_ready.
- On issue: inflight_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap at 0xFFFF_FFFC -> 0).
- On no issue: inflight_q<=0 and pc_q holds. Memory data for a non-issued cycle is ignored.
- Enqueue: when inflight_q=1 and no redirect, {inflight_pc_q, imem_inst} is written at the clock edge. The entry becomes visible on out_* the next cycle.
- The queue cannot overflow: the issue rule reserves a slot for every in-flight read.
- Handshake: out_* stay stable while out_valid && !out_ready. Pop and enqueue in the same cycle are both honoured.
- Redirect cycle N: imem_kill=1 and out_valid is forced 0, so no pop occurs.
  - The queue is flushed and the data arriving in N is discarded (inflight_q<=0).
  - pc_q<=redirect_pc.
- N+1: redirect_pc is issued. N+2: its word arrives and is enqueued. N+3: out_valid=1 with out_pc=redirect_pc. Redirect-to-output latency is 3 cycles.
- Back-to-back redirects: the last one wins and each restarts the 3-cycle sequence.
- Steady streaming with out_ready=1 sustains 1 instr/cycle after a 2-cycle fill: reset release -> first out_valid at cycle 2.
- Reset mid-operation clears the queue and inflight immediately. Stale imem_inst is ignored because inflight_q=0.
- States, implicit in inflight_q/count: FILL (count=0), RUN, FULL (count+inflight=FQ_DEPTH, no issue), REDIRECT (single cycle).

Optional Feature:
IFETCH_TRACE_EN:
- Defined: simulation-only $display("%x: %x", out_pc, out_inst) on every accepted handshake (out_valid && out_ready), plus "REDIR %x" on each redirect.
- Undefined: no display code and no behavioural difference.

Decomposition:
Package ifetch_pkg holds:
- typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}
- localparam INST_NOP = 32'h0000_0013
- localparam XLEN = 32

Sub-module fetch_fifo: FQ_DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, and empty/full flags, reset async active-low.

Test Plan:
1. Reset release, out_ready=1, mem[i]=i+1 -> out_valid rises at cycle 2; out_pc sequence 0,4,8,...; out_inst 1,2,3; one per cycle.
2. out_ready=0 for 10 cycles after streaming starts -> count saturates at 4, imem_pc freezes, out_pc/out_inst stable; on release, no lost or duplicate pc.
3. redirect_valid pulse with redirect_pc=0x100 at cycle N -> imem_kill=1 at N, out_valid=0 at N, N+1, N+2; out_pc=0x100 at N+3, then 0x104.
4. redirect_valid and out_ready both high with a valid head -> head not consumed, queue flushed, next out_pc=redirect target.
5. redirect_pc=0x103 -> fetch from 0x100; also redirect to 0xFFFF_FFFC -> next pc 0x0 (wrap).
6. rst_n asserted mid-stream with 3 entries queued -> out_valid=0 immediately; after release, out_pc restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch slice.
//   fetch_entry_t : one fetched instruction with the pc it came from
//   INST_NOP      : canonical RV32 nop encoding
//   XLEN          : architectural address/data width
//   align_word()  : clears the byte-offset bits of an address
package ifetch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, wr_pc/inst  : write request and data (ignored when full without pop)
//   pop               : remove head (ignored when empty)
//   flush             : drop all entries; wins over push/pop
//   rd_pc, rd_inst    : head entry (valid when !empty)
//   count, empty, full: occupancy status
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              wr_pc,
    input  logic [31:0]              wr_inst,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_inst,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // qualify requests against occupancy; a push into a full queue is legal only alongside a pop
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
            do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
        end
    end

    // pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= '{pc: wr_pc, inst: wr_inst};
        end
    end

    assign rd_pc   = mem_r[rd_ptr_r].pc;
    assign rd_inst = mem_r[rd_ptr_r].inst;
    assign count   = count_r;
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign full    = (count_r == DEPTH_C);

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch initiator for a 1-cycle synchronous-read imem.
// Issues sequential word addresses, tracks the single in-flight read, buffers
// returned words in a fetch queue and hands {pc, inst} to decode over
// valid/ready. A redirect kills the current read, flushes the queue and
// restarts fetch at the target (3 cycles until the target reaches out_*).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_pc, imem_kill    : address / squash to instruction memory
//   imem_inst             : memory read data (1 cycle after address)
//   redirect_valid/_pc    : single-cycle control-flow change from execute
//   out_valid/ready       : decode handshake
//   out_pc, out_inst      : head of queue (0 when queue empty)
// Optional: define IFETCH_TRACE_EN for a simulation trace of accepted
// instructions and redirects.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    output logic        imem_kill,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int          CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

    logic [31:0]   pc_r;
    logic [31:0]   inflight_pc_r;
    logic          inflight_r;
    logic [31:0]   redir_pc_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_inst_s;
    logic [CW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   occ_s;
    logic          unused_s;

    assign redir_pc_s = align_word(redirect_pc);
    assign unused_s   = ^{redirect_pc[1:0], full_s};

    // handshake, enqueue and issue decisions; the occupancy sum reserves a queue
    // slot for the read already in flight so the queue can never overflow
    always_comb begin
        out_valid = 1'b0;
        if (redirect_valid) begin
            out_valid = 1'b0;
        end else begin
            out_valid = !empty_s;
        end
        pop_s   = out_valid && out_ready;
        push_s  = inflight_r && !redirect_valid;
        occ_s   = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
        issue_s = !redirect_valid && (occ_s < DEPTH_C);
    end

    // memory-side and decode-side output values
    always_comb begin
        imem_kill = redirect_valid;
        if (redirect_valid) begin
            imem_pc = redir_pc_s;
        end else begin
            imem_pc = pc_r;
        end
        if (empty_s) begin
            out_pc   = 32'h0000_0000;
            out_inst = 32'h0000_0000;
        end else begin
            out_pc   = head_pc_s;
            out_inst = head_inst_s;
        end
    end

    // fetch pointer and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc_r       <= redir_pc_s;
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
            pc_r          <= pc_r + 32'd4;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (redirect_valid),
        .wr_pc   (inflight_pc_r),
        .wr_inst (imem_inst),
        .rd_pc   (head_pc_s),
        .rd_inst (head_inst_s),
        .count   (count_s),
        .empty   (empty_s),
        .full    (full_s)
    );

`ifdef IFETCH_TRACE_EN
    // simulation trace of accepted instructions and redirects
    always @(posedge clk) begin
        if (rst_n && pop_s) begin
            $display("%x: %x", out_pc, out_inst);
        end
        if (rst_n && redirect_valid) begin
            $display("REDIR %x", redir_pc_s);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl. The memory model returns (pc>>2)+1 for a
// word address, so mem[i] = i+1, and all-zero when killed.
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic        imem_kill;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int          total;
    int          bad;
    logic [31:0] exp_pc;

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_kill      (imem_kill),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read instruction memory
    initial imem_inst = 32'h0;
    always @(posedge clk) begin
        if (imem_kill) imem_inst <= 32'h0;
        else           imem_inst <= {2'b00, imem_pc[31:2]} + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // n consecutive cycles of streaming, one instruction per cycle
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("stream_valid", {31'h0, out_valid}, 32'h1);
            chk("stream_pc", out_pc, exp_pc);
            chk("stream_inst", out_inst, {2'b00, exp_pc[31:2]} + 32'd1);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // redirect pulse at N; out_valid low for N..N+2; exp_pc set for N+3 onward
    task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] aligned);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        #1;
        chk("redir_kill", {31'h0, imem_kill}, 32'h1);
        chk("redir_valid_n", {31'h0, out_valid}, 32'h0);
        chk("redir_imem_pc", imem_pc, aligned);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("redir_n1_kill", {31'h0, imem_kill}, 32'h0);
        chk("redir_n1_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_n1_imem_pc", imem_pc, aligned);
        @(negedge clk); #1;
        chk("redir_n2_valid", {31'h0, out_valid}, 32'h0);
        chk("redir_n2_imem_pc", imem_pc, aligned + 32'd4);
        exp_pc = aligned;
    endtask

    task automatic chk_reset_outs();
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_kill", {31'h0, imem_kill}, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total          = 0;
        bad            = 0;
        exp_pc         = 32'h0;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outs();

        // test 1: fill latency and streaming
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("c0_valid", {31'h0, out_valid}, 32'h0);
        chk("c0_imem_pc", imem_pc, 32'h0);
        @(negedge clk); #1;
        chk("c1_valid", {31'h0, out_valid}, 32'h0);
        chk("c1_imem_pc", imem_pc, 32'h4);
        exp_pc = 32'h0;
        stream(5);                       // pcs 0x0..0x10

        // test 2: backpressure saturates the queue, imem_pc freezes
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("bp_k_pc", out_pc, 32'h14);
        chk("bp_k_imem_pc", imem_pc, 32'h1c);
        @(negedge clk); #1;
        chk("bp_k1_imem_pc", imem_pc, 32'h20);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_pc", out_pc, 32'h14);
            chk("bp_inst", out_inst, 32'h6);
            chk("bp_imem_pc", imem_pc, 32'h24);
        end
        exp_pc = 32'h14;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("rel_pc", out_pc, exp_pc);
        chk("rel_valid", {31'h0, out_valid}, 32'h1);
        exp_pc = exp_pc + 32'd4;
        stream(7);                       // 0x18..0x30 without gaps

        // tests 3/4: redirect while a valid head is offered with out_ready=1
        do_redirect(32'h0000_0100, 32'h0000_0100);
        stream(2);

        // test 5: unaligned target and wrap at the top of the address space
        do_redirect(32'h0000_0203, 32'h0000_0200);
        stream(2);
        do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        stream(3);                       // 0xFFFFFFFC, 0x0, 0x4

        // back-to-back redirects: last one wins
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1;
        chk("b2b_first_imem_pc", imem_pc, 32'h300);
        do_redirect(32'h0000_0400, 32'h0000_0400);
        stream(2);

        // test 6: reset mid-stream with three entries queued
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rr_c0_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk); #1;
        chk("rr_c1_valid", {31'h0, out_valid}, 32'h0);
        exp_pc = 32'h0;
        stream(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
